// File: rtl/axis_frame_tagger_if.sv
// Stream bundle for axis_frame_tagger: the upstream s_* side and the downstream m_* side.
// A beat transfers on a rising clk edge where tvalid and tready are both 1; tvalid
// never waits on tready, and the sender holds tdata/tlast stable until the transfer.
interface axis_frame_tagger_if #(
  parameter int DWIDTH = 128
);
  logic [DWIDTH-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [DWIDTH-1:0]   m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic [DWIDTH/8-1:0] m_tkeep;
  logic                m_tlast;

  // slave: the tagger itself; master: whatever drives its input and sinks its output
  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tkeep, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tkeep, m_tlast
  );
endinterface

// File: rtl/axis_frame_tagger.sv
// Frames a 128-bit stream for a DMA S2MM channel: two-entry skid buffer, tlast every
// frame_len beats (or early on flush), full tkeep, and a wrapping completed-frame counter.
module axis_frame_tagger #(
  parameter int DWIDTH = 128,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 flush,
  axis_frame_tagger_if.slave   bus,
  output logic [31:0]          frame_cnt,
  output logic                 busy,
  output logic                 dbg_state
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_IN_FRAME = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic              flush_pend, flush_pend_n;
  logic [LEN_W-1:0]  len_eff;
  logic              tag_last;
  logic              acc;

  logic              s_tready_q;
  logic              out_valid, out_valid_n;
  logic [DWIDTH-1:0] out_data, out_data_n;
  logic              out_last, out_last_n;
  logic              skid_valid, skid_valid_n;
  logic [DWIDTH-1:0] skid_data, skid_data_n;
  logic              skid_last, skid_last_n;
  logic              drain;
  logic              load_out;

  assign acc     = bus.s_tvalid & s_tready_q;
  assign len_eff = (frame_len == '0) ? LEN_ONE : frame_len;

  // Tagging happens at acceptance, so the last flag travels with the beat.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    len_n        = len_q;
    flush_pend_n = flush_pend;
    tag_last     = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          len_n = len_eff;
          if (len_eff == LEN_ONE) begin
            tag_last = 1'b1;
          end else begin
            cnt_n   = LEN_ONE;
            state_n = S_IN_FRAME;
          end
        end
      end
      S_IN_FRAME: begin
        if (acc && (flush_pend || (cnt == len_q - LEN_ONE))) begin
          // a flush arriving with the closing beat has nothing left to close
          tag_last     = 1'b1;
          cnt_n        = '0;
          state_n      = S_IDLE;
          flush_pend_n = 1'b0;
        end else begin
          if (acc) begin
            cnt_n = cnt + LEN_ONE;
          end
          if (flush) begin
            flush_pend_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= LEN_ONE;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      len_q      <= len_n;
      flush_pend <= flush_pend_n;
    end
  end

  assign drain    = out_valid & bus.m_tready;
  assign load_out = ~out_valid | drain;

  // The skid entry always refills the output first so beat order is kept.
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_last_n   = out_last;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_last_n  = skid_last;
    if (load_out) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        out_last_n   = skid_last;
        skid_valid_n = 1'b0;
      end else if (acc) begin
        out_valid_n = 1'b1;
        out_data_n  = bus.s_tdata;
        out_last_n  = tag_last;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (acc) begin
      skid_valid_n = 1'b1;
      skid_data_n  = bus.s_tdata;
      skid_last_n  = tag_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      s_tready_q <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_last   <= out_last_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_last  <= skid_last_n;
      s_tready_q <= ~skid_valid_n;
      if (drain && out_last) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tdata  = out_data;
  assign bus.m_tlast  = out_last;
  assign bus.m_tkeep  = '1;

  assign busy      = (state == S_IN_FRAME) | out_valid | skid_valid;
  assign dbg_state = state;

endmodule

// File: doc/axis_frame_tagger.md
# axis_frame_tagger

Frames the 128-bit output stream of the data-routing stage (ports d/e) for the downstream AXI DMA S2MM channel. It re-times the stream through a full-throughput two-entry skid buffer and marks `m_tlast` on the final beat of each frame of `frame_len` beats. It drives full `m_tkeep` and counts completed frames for software status. One instance sits directly after each of `m_out_d` and `m_out_e`.

## Interface
- `DWIDTH`, 128, data width in bits; must be a multiple of 8.
- `LEN_W`, 16, width of the frame-length field.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low. Clock is `clk`.
- `frame_len`  in  LEN_W  beats per frame, sampled at frame start; 0 is treated as 1.
- `flush`  in  1  single-cycle pulse; closes the current frame early.
- `s_tdata`  in  DWIDTH  input data from the route stage.
- `s_tvalid`  in  1  input valid.
- `s_tready`  out  1  input ready; registered.
- `m_tdata`  out  DWIDTH  output data to DMA.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  output ready.
- `m_tkeep`  out  DWIDTH/8  byte enables; always all ones.
- `m_tlast`  out  1  last beat of frame.
- `frame_cnt`  out  32  count of frames transferred on the output; wraps.
- `busy`  out  1  a frame is open or the buffer holds data.

## Operation
- **Skid buffer: storage.** Output register (data + last flag) plus one skid register.
- **Skid buffer: ready.** `s_tready` = skid register empty, registered.
- **Skid buffer: bubbles.** None; sustains one beat per cycle while `m_tready`=1.
- **Acceptance.** Input accepted when `s_tvalid & s_tready`.
- **Tagging.** Done at acceptance. The last flag is stored with the beat and follows it through the buffer.
- **State machine, IDLE.** Beat counter `cnt`=0.
  - First accepted beat latches `len_q` = max(`frame_len`, 1).
  - If `len_q`==1, that beat is tagged last and the state stays IDLE.
  - Otherwise `cnt`=1 and the state moves to IN_FRAME.
- **State machine, IN_FRAME.** Each accepted beat increments `cnt`.
  - The beat with `cnt`==`len_q`-1 is tagged last; `cnt` returns to 0 and the state returns to IDLE.
- **frame_len changes.** Changes while IN_FRAME are ignored until the next frame start.
- **flush in IN_FRAME.** Sets `flush_pend`. The next accepted beat is tagged last regardless of `cnt`; `cnt` returns to 0, the state returns to IDLE and `flush_pend` clears.
- **flush in IDLE.** No effect; `flush_pend` is not set.
- **flush and beat in the same cycle (IN_FRAME).** `flush_pend` is not yet set, so that beat is tagged by the normal count rule. The following beat is tagged last unless the frame already closed on the concurrent beat; in that case `flush_pend` is discarded.
- **frame_cnt.** +1 on each cycle with `m_tvalid & m_tready & m_tlast`; wraps 0xFFFFFFFF→0.
- **busy.** 1 when state==IN_FRAME, or when the output or skid register is occupied.
- **Data integrity.** Order and content of data beats are preserved exactly; no beat is dropped or duplicated.

## Timing
- **Reset values.** While `rst_n`=0 at a clk edge:
  - outputs: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0, `frame_cnt`=0, `busy`=0, `m_tkeep`=all ones;
  - internal: state=IDLE, `cnt`=0, `flush_pend`=0.
- **After reset.** `s_tready`=1 on the first cycle after `rst_n` rises.
- **Reset mid-frame.** Buffered beats are discarded; the next beat starts a new frame.
- **Latency.** A beat accepted at edge N is presented on `m_tdata` after edge N, i.e. 1 cycle, when the output register was empty or being drained at edge N.
- **Backpressure.**
  - When `m_tready`=0 with the output register full, the next accepted beat goes to the skid register.
  - `s_tready` falls the cycle after the skid register fills.
  - `s_tready` rises the cycle after the skid register drains; the skid register drains first, preserving order.
- **AXI-Stream stability.** While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` are held stable.
- **Simultaneous events.** Accepting an input and emitting an output in the same cycle keeps occupancy unchanged.

## Test plan
- **Fixed frames, no stall.** `frame_len`=4; 12 beats with values 0..11 at full rate, `m_tready`=1.
  - `m_tlast` on beats 3, 7, 11.
  - `frame_cnt`=3.
  - Output cycle = input cycle + 1.
- **Backpressure.** `frame_len`=3; `m_tready` toggles 1,0,0,1 repeating; random `s_tvalid`; 300 beats.
  - Output sequence equals input sequence.
  - `m_tlast` every 3rd beat.
  - `s_tready` never low with skid register empty.
  - No data change while stalled.
- **Length change mid-frame.** `frame_len`=5; after beat 2, change to 2.
  - First `m_tlast` on beat 4.
  - Next frame ends on beat 6.
- **Flush.** `frame_len`=8; send 3 beats, pulse `flush`, send 1 beat.
  - The 4th beat carries `m_tlast`.
  - `frame_cnt`=1.
  - The next frame is 8 beats.
- **Flush in IDLE and len=0.** `flush` pulse in IDLE, then `frame_len`=0 with 3 beats.
  - Every beat has `m_tlast`=1.
  - `frame_cnt`=3.
- **Reset mid-frame.** `frame_len`=4; send 2 beats with `m_tready`=0, then assert `rst_n`=0 for 1 cycle.
  - All outputs return to their reset values.
  - The following 4 beats form one complete frame.
